fact_core: RTL and testbench

//  Memory-mapped factorial engine: the register/compute end of the factorial peripheral.
//  It consumes the decoded write strobes (we1 = N register, we2 = GO register) and the

---
 rtl/fact_core_if.sv | 14 +
 rtl/fact_core.sv | 82 ++++++++
 tb/tb_fact_core.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fact_core_if.sv
// Processor-side bus into the factorial engine: decoded write strobes, write data,
// read select and the combinational read-back.
interface fact_core_if #(
    parameter int unsigned WIDTH = 32
);
    logic             we1;
    logic             we2;
    logic [WIDTH-1:0] wd;
    logic [1:0]       rdsel;
    logic [WIDTH-1:0] rd;

    modport master (output we1, output we2, output wd, output rdsel, input rd);
    modport slave  (input we1, input we2, input wd, input rdsel, output rd);
endinterface

// File: rtl/fact_core.sv
// Memory-mapped factorial engine: N and GO registers, one multiply per cycle,
// register read-back selected by rdsel.
module fact_core #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_WIDTH = 4,
    parameter int unsigned MAX_N   = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    fact_core_if.slave  bus
);
    typedef enum logic {IDLE, CALC} state_t;

    localparam logic [N_WIDTH-1:0] MAX_N_L = N_WIDTH'(MAX_N);
    localparam logic [N_WIDTH-1:0] ONE_N   = N_WIDTH'(1);

    state_t             state_q;
    logic [N_WIDTH-1:0] n_q;
    logic [N_WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   result_q;
    logic               done_q;
    logic               err_q;
    logic               start;

    assign start = bus.we2 && bus.wd[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            n_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.we1) begin
                        n_q <= bus.wd[N_WIDTH-1:0];
                    end
                    // A same-cycle we1 does not affect this start: n_q here is the old value.
                    if (start) begin
                        if (n_q <= MAX_N_L) begin
                            acc_q   <= WIDTH'(1);
                            cnt_q   <= n_q;
                            done_q  <= 1'b0;
                            err_q   <= 1'b0;
                            state_q <= CALC;
                        end else begin
                            result_q <= '0;
                            err_q    <= 1'b1;
                            done_q   <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (cnt_q <= ONE_N) begin
                        result_q <= acc_q;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        acc_q <= acc_q * WIDTH'(cnt_q);
                        cnt_q <= cnt_q - ONE_N;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.rd = '0;
        case (bus.rdsel)
            2'b00:   bus.rd = WIDTH'(n_q);
            2'b01:   bus.rd = WIDTH'(state_q == CALC);
            2'b10:   bus.rd = WIDTH'({err_q, done_q});
            default: bus.rd = result_q;
        endcase
    end
endmodule

// File: tb/tb_fact_core.sv
// Directed bench for fact_core: register writes and reads through the bus interface,
// completion latency, overflow rejection, ignored writes while busy and async reset abort.
module tb_fact_core;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fact_core_if #(.WIDTH(32)) bus ();

    fact_core #(
        .WIDTH   (32),
        .N_WIDTH (4),
        .MAX_N   (12)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic rd_reg(input logic [1:0] sel, output logic [31:0] val);
        bus.rdsel = sel;
        #1;
        val = bus.rd;
    endtask

    task automatic write_n(input logic [31:0] v);
        @(negedge clk);
        bus.we1 = 1'b1;
        bus.wd  = v;
        @(negedge clk);
        bus.we1 = 1'b0;
        bus.wd  = '0;
    endtask

    // Returns at the first negedge after the start-write edge.
    task automatic go();
        @(negedge clk);
        bus.we2 = 1'b1;
        bus.wd  = 32'd1;
        @(negedge clk);
        bus.we2 = 1'b0;
        bus.wd  = '0;
    endtask

    // Counts edges after the start-write edge until done reads 1, and cycles seen busy.
    task automatic wait_done(input string tag, output int edges, output int busy_cnt);
        logic [31:0] st;
        logic [31:0] b;
        edges    = 0;
        busy_cnt = 0;
        forever begin
            rd_reg(2'b10, st);
            rd_reg(2'b01, b);
            if (st[0]) break;
            busy_cnt += int'(b[0]);
            if (edges >= 100) begin
                check({tag, "_timeout"}, 32'(edges), 32'd0);
                break;
            end
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic run_job(input string tag, input logic [31:0] n, input int exp_edges,
                           input logic [31:0] exp_result);
        int edges;
        int busy_cnt;
        logic [31:0] v;
        write_n(n);
        go();
        wait_done(tag, edges, busy_cnt);
        check({tag, "_latency"}, 32'(edges), 32'(exp_edges));
        rd_reg(2'b10, v);
        check({tag, "_status"}, v, 32'd1);
        rd_reg(2'b11, v);
        check({tag, "_result"}, v, exp_result);
    endtask

    initial begin
        logic [31:0] v;
        int edges;
        int busy_cnt;

        rst_n     = 1'b0;
        bus.we1   = 1'b0;
        bus.we2   = 1'b0;
        bus.wd    = '0;
        bus.rdsel = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state of all four read-backs
        for (int unsigned s = 0; s < 4; s++) begin
            rd_reg(2'(s), v);
            check($sformatf("reset_rd%0d", s), v, 32'd0);
        end

        // n=5: 5 busy cycles, then 120
        write_n(32'd5);
        rd_reg(2'b00, v);
        check("n_readback", v, 32'd5);
        go();
        wait_done("n5", edges, busy_cnt);
        check("n5_latency", 32'(edges), 32'd5);
        check("n5_busy_cycles", 32'(busy_cnt), 32'd5);
        rd_reg(2'b10, v);
        check("n5_status", v, 32'd1);
        rd_reg(2'b11, v);
        check("n5_result", v, 32'd120);
        rd_reg(2'b01, v);
        check("n5_idle_after", v, 32'd0);

        run_job("n0", 32'd0, 1, 32'd1);
        run_job("n1", 32'd1, 1, 32'd1);
        run_job("n12", 32'd12, 12, 32'd479001600);
        run_job("n7", 32'd7, 7, 32'd5040);

        // n=13 overflows: rejected on the start edge, never busy
        write_n(32'd13);
        go();
        rd_reg(2'b01, v);
        check("n13_busy", v, 32'd0);
        rd_reg(2'b10, v);
        check("n13_status", v, 32'd3);
        rd_reg(2'b11, v);
        check("n13_result", v, 32'd0);
        @(negedge clk);
        rd_reg(2'b01, v);
        check("n13_busy_later", v, 32'd0);

        // n=10 with a write to N and a GO write while busy: both ignored
        write_n(32'd10);
        go();
        bus.we1 = 1'b1;
        bus.wd  = 32'd3;
        @(negedge clk);
        bus.we1 = 1'b0;
        bus.we2 = 1'b1;
        bus.wd  = 32'd1;
        @(negedge clk);
        bus.we2 = 1'b0;
        bus.wd  = '0;
        wait_done("n10", edges, busy_cnt);
        check("n10_latency", 32'(edges + 2), 32'd10);
        rd_reg(2'b11, v);
        check("n10_result", v, 32'd3628800);
        rd_reg(2'b00, v);
        check("n10_n_kept", v, 32'd10);
        rd_reg(2'b10, v);
        check("n10_status", v, 32'd1);

        // Simultaneous we1 and we2: start uses old n (10), n takes 5
        @(negedge clk);
        bus.we1 = 1'b1;
        bus.we2 = 1'b1;
        bus.wd  = 32'd5;
        @(negedge clk);
        bus.we1 = 1'b0;
        bus.we2 = 1'b0;
        bus.wd  = '0;
        wait_done("both", edges, busy_cnt);
        check("both_latency", 32'(edges), 32'd10);
        rd_reg(2'b11, v);
        check("both_result", v, 32'd3628800);
        rd_reg(2'b00, v);
        check("both_n_new", v, 32'd5);

        // Async reset mid-job (n=8, after 3 edges)
        write_n(32'd8);
        go();
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        for (int unsigned s = 0; s < 4; s++) begin
            rd_reg(2'(s), v);
            check($sformatf("abort_rd%0d", s), v, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        rd_reg(2'b10, v);
        check("abort_no_done", v, 32'd0);
        rd_reg(2'b01, v);
        check("abort_idle", v, 32'd0);
        run_job("n4", 32'd4, 4, 32'd24);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion before 200000");
        $fatal(1);
    end
endmodule
